hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Next-generation hazard and forwarding controller for the xgriscv pipeline.
- Replaces the fixed one-cycle load-use check with a per-register scoreboard of outstanding long-latency ops (variable-latency loads, multi-cycle mul/div).
- Generates IF/ID stall and ID/EX bubble, plus EX-stage operand forwarding selects including a completion-bus source.
- Sits beside the ID/EX stage registers; consumes register indices from D, E, M, W and from the long-op completion bus.

Parameters:
- RFIDX_WIDTH, 5, register index width.
- NREG, 32, architectural registers (2**RFIDX_WIDTH).
- MAX_OUT, 4, maximum outstanding long-latency ops.
- CNT_WIDTH, 3, width of outstanding counter (must hold MAX_OUT).
- BYPASS_DONE, 1, 1 = a completion in the same cycle resolves a D-stage RAW with no stall.
- FWD_STORE_DATA, 0, 1 = forward rs2 of stores in E; 0 = store data is not forwarded on B.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- rs1D, rs2D, rdD  in  RFIDX_WIDTH each  D-stage source and destination indices
- rs1_usedD, rs2_usedD  in  1 each  D-stage instruction reads rs1 / rs2
- regwriteD  in  1  D-stage instruction writes rdD
- longopD  in  1  D-stage instruction is a long-latency op
- alloc_valid  in  1  long op leaving E this cycle (not flushed); allocate at clock edge
- alloc_rd  in  RFIDX_WIDTH  destination of that long op
- done_valid  in  1  long-op result on completion bus this cycle
- done_rd  in  RFIDX_WIDTH  destination of the completing op
- rs1E, rs2E  in  RFIDX_WIDTH each  E-stage sources
- stypeE  in  1  E-stage instruction is a store
- regwriteM, rdM  in  1 / RFIDX_WIDTH  M-stage write; long ops present regwriteM=0
- regwriteW, rdW  in  1 / RFIDX_WIDTH  W-stage write; long ops present regwriteW=0
- branch_flush  in  1  E-stage redirect
- stallF, stallD  out  1 each  1 = hold PC / hold IF/ID
- flushD, flushE  out  1 each  1 = bubble IF/ID / ID/EX
- forwardA, forwardB  out  2 each  00 RF, 10 M, 01 W, 11 completion bus
- pending_cnt  out  CNT_WIDTH  outstanding long ops
- sb_err  out  1  sticky protocol error

Behaviour:
- Async reset (rstn=0): pend[NREG-1:0]=0, pending_cnt=0, sb_err=0.
- All other outputs are combinational and evaluate to 0 with idle inputs.
- Clock edge, alloc only (alloc_valid && alloc_rd!=0): pend[alloc_rd]=1, cnt+1.
- Clock edge, done only (done_valid): if pend[done_rd], clear it and cnt-1. Otherwise no state change and sb_err=1 (sticky until reset).
- Alloc and done to different registers in the same cycle: both apply; cnt unchanged.
- Alloc and done to the same register in the same cycle: bit ends at 1, cnt unchanged.
- alloc_rd==0 allocates nothing.
- Alloc when cnt==MAX_OUT and no done: ignored, sb_err=1.
- Register x0 never pending and never forwarded.
- Per-source RAW term (X = 1, 2): rsX_usedD && rsXD!=0 && (pend[rsXD] || (alloc_valid && alloc_rd==rsXD)).
- RAW is masked when BYPASS_DONE=1 && done_valid && done_rd==rsXD && !(alloc_valid && alloc_rd==rsXD).
- WAW: regwriteD && rdD!=0 && (pend[rdD] || (alloc_valid && alloc_rd==rdD)).
- Structural: longopD && (pending_cnt + alloc_valid - (done_valid && pend[done_rd])) >= MAX_OUT.
- stall = RAW | WAW | structural.
- If branch_flush=1: stallF=stallD=0, flushD=1, flushE=1.
- Else: stallF=stallD=stall, flushD=0, flushE=stall.
- branch_flush never clears the scoreboard; allocated ops are committed.
- forwardA priority: 11 if done_valid && done_rd==rs1E; else 10 if regwriteM && rdM==rs1E; else 01 if regwriteW && rdW==rs1E; else 00. The rs1E!=0 requirement applies to all three sources.
- forwardB: same priority on rs2E.
- forwardB is forced to 00 when stypeE=1 and FWD_STORE_DATA=0.
- Completion bus wins over M/W: the WAW stall guarantees every M/W writer to the same register is older.

Test Plan:
- Load-use: alloc_valid=1, alloc_rd=5; D has rs1D=5, rs1_usedD=1 -> stallF=stallD=flushE=1 that cycle; next cycle pend[5]=1, stall stays 1 until done_rd=5 pulses. With BYPASS_DONE=1, stall=0 in the done cycle.
- WAW and x0: pend[7]=1; D has regwriteD=1, rdD=7 -> stall=1. Repeat with rdD=0 -> stall=0. alloc_rd=0 -> pending_cnt unchanged.
- Structural: MAX_OUT=4, four allocs to regs 1-4 -> pending_cnt=4; longopD=1 -> stall=1. done_rd=2 in the same cycle -> stall=0.
- Simultaneous/error events: alloc_rd=9 and done_rd=9 in one cycle with pend[9]=1 -> pend[9]=1, cnt unchanged. done_rd=12 with pend[12]=0 -> sb_err=1, stays 1 until rstn=0.
- Forwarding priority: rs1E=3 with regwriteM, rdM=3, regwriteW, rdW=3, done_rd=3 -> forwardA=11. Drop done -> 10. Drop M -> 01. stypeE=1, rs2E=rdM, FWD_STORE_DATA=0 -> forwardB=00.
- Flush and reset: stall condition plus branch_flush=1 -> stallF=0, flushD=flushE=1, pend unchanged. Assert rstn=0 mid-stall -> pend, pending_cnt, sb_err clear immediately (asynchronously, no clock edge needed).

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Bundle of all D/E/M/W, allocation, completion and hazard-control signals
// exchanged between the pipeline and the hazard scoreboard.
//   master : pipeline side (drives indices/valids, receives stalls/forwards)
//   slave  : scoreboard side
interface hazard_scoreboard_if #(
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned CNT_WIDTH   = 3
);
  logic [RFIDX_WIDTH-1:0] rs1D, rs2D, rdD;
  logic                   rs1_usedD, rs2_usedD, regwriteD, longopD;
  logic                   alloc_valid;
  logic [RFIDX_WIDTH-1:0] alloc_rd;
  logic                   done_valid;
  logic [RFIDX_WIDTH-1:0] done_rd;
  logic [RFIDX_WIDTH-1:0] rs1E, rs2E;
  logic                   stypeE;
  logic                   regwriteM, regwriteW;
  logic [RFIDX_WIDTH-1:0] rdM, rdW;
  logic                   branch_flush;
  logic                   stallF, stallD, flushD, flushE;
  logic [1:0]             forwardA, forwardB;
  logic [CNT_WIDTH-1:0]   pending_cnt;
  logic                   sb_err;

  modport master (
    output rs1D, rs2D, rdD, rs1_usedD, rs2_usedD, regwriteD, longopD,
           alloc_valid, alloc_rd, done_valid, done_rd, rs1E, rs2E, stypeE,
           regwriteM, rdM, regwriteW, rdW, branch_flush,
    input  stallF, stallD, flushD, flushE, forwardA, forwardB,
           pending_cnt, sb_err
  );

  modport slave (
    input  rs1D, rs2D, rdD, rs1_usedD, rs2_usedD, regwriteD, longopD,
           alloc_valid, alloc_rd, done_valid, done_rd, rs1E, rs2E, stypeE,
           regwriteM, rdM, regwriteW, rdW, branch_flush,
    output stallF, stallD, flushD, flushE, forwardA, forwardB,
           pending_cnt, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller with a per-register scoreboard of
// outstanding long-latency ops (variable-latency loads, mul/div).
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   hz        : hazard_scoreboard_if.slave -- D-stage indices, long-op
//               allocate/complete events, E/M/W indices, branch flush in;
//               stallF/stallD/flushD/flushE, forwardA/B (00 RF, 10 M,
//               01 W, 11 completion bus), pending_cnt, sticky sb_err out.
module hazard_scoreboard #(
  parameter int unsigned RFIDX_WIDTH    = 5,
  parameter int unsigned NREG           = 32,
  parameter int unsigned MAX_OUT        = 4,
  parameter int unsigned CNT_WIDTH      = 3,
  parameter bit          BYPASS_DONE    = 1'b1,
  parameter bit          FWD_STORE_DATA = 1'b0
) (
  input logic              clk,
  input logic              rstn,
  hazard_scoreboard_if.slave hz
);

  localparam logic [CNT_WIDTH:0] MAX_V = (CNT_WIDTH+1)'(MAX_OUT);

  logic [NREG-1:0]      pend;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 err;

  logic alloc_eff, done_hit, alloc_acc;
  logic raw1, raw2, waw, structural, stall;
  logic [CNT_WIDTH:0] occ_lhs, occ_rhs;

  assign alloc_eff = hz.alloc_valid && (hz.alloc_rd != '0);
  assign done_hit  = hz.done_valid && pend[hz.done_rd];
  // A full scoreboard still accepts an alloc when a completion frees a slot.
  assign alloc_acc = alloc_eff && ((cnt != MAX_V[CNT_WIDTH-1:0]) || done_hit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      // Clear first, then set: same-register alloc+done leaves the bit at 1.
      logic [NREG-1:0] pend_n;
      pend_n = pend;
      if (done_hit)  pend_n[hz.done_rd]  = 1'b0;
      if (alloc_acc) pend_n[hz.alloc_rd] = 1'b1;
      pend <= pend_n;
      cnt  <= cnt + CNT_WIDTH'(alloc_acc) - CNT_WIDTH'(done_hit);
      if ((hz.done_valid && !done_hit) || (alloc_eff && !alloc_acc))
        err <= 1'b1;
    end
  end

  assign hz.pending_cnt = cnt;
  assign hz.sb_err      = err;

  always_comb begin
    logic a1, a2, ad, m1, m2;
    a1 = hz.alloc_valid && (hz.alloc_rd == hz.rs1D);
    a2 = hz.alloc_valid && (hz.alloc_rd == hz.rs2D);
    ad = hz.alloc_valid && (hz.alloc_rd == hz.rdD);
    m1 = BYPASS_DONE && hz.done_valid && (hz.done_rd == hz.rs1D) && !a1;
    m2 = BYPASS_DONE && hz.done_valid && (hz.done_rd == hz.rs2D) && !a2;
    raw1 = hz.rs1_usedD && (hz.rs1D != '0) && (pend[hz.rs1D] || a1) && !m1;
    raw2 = hz.rs2_usedD && (hz.rs2D != '0) && (pend[hz.rs2D] || a2) && !m2;
    waw  = hz.regwriteD && (hz.rdD != '0) && (pend[hz.rdD] || ad);
    // cnt + alloc - done >= MAX rearranged to avoid underflow.
    occ_lhs = {1'b0, cnt} + (CNT_WIDTH+1)'(hz.alloc_valid);
    occ_rhs = MAX_V + (CNT_WIDTH+1)'(done_hit);
    structural = hz.longopD && (occ_lhs >= occ_rhs);
    stall = raw1 || raw2 || waw || structural;
  end

  always_comb begin
    if (hz.branch_flush) begin
      hz.stallF = 1'b0;
      hz.stallD = 1'b0;
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
    end else begin
      hz.stallF = stall;
      hz.stallD = stall;
      hz.flushD = 1'b0;
      hz.flushE = stall;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [RFIDX_WIDTH-1:0] rs,
    input logic dv, input logic [RFIDX_WIDTH-1:0] drd,
    input logic mv, input logic [RFIDX_WIDTH-1:0] mrd,
    input logic wv, input logic [RFIDX_WIDTH-1:0] wrd
  );
    if (rs == '0)                fwd_sel = 2'b00;
    else if (dv && drd == rs)    fwd_sel = 2'b11;
    else if (mv && mrd == rs)    fwd_sel = 2'b10;
    else if (wv && wrd == rs)    fwd_sel = 2'b01;
    else                         fwd_sel = 2'b00;
  endfunction

  always_comb begin
    hz.forwardA = fwd_sel(hz.rs1E, hz.done_valid, hz.done_rd,
                          hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
    if (hz.stypeE && !FWD_STORE_DATA)
      hz.forwardB = 2'b00;
    else
      hz.forwardB = fwd_sel(hz.rs2E, hz.done_valid, hz.done_rd,
                            hz.regwriteM, hz.rdM, hz.regwriteW, hz.rdW);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int RW = 5;
  localparam int CW = 3;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RFIDX_WIDTH(RW), .CNT_WIDTH(CW)) hif ();

  hazard_scoreboard #(
    .RFIDX_WIDTH(RW), .NREG(32), .MAX_OUT(MAXO), .CNT_WIDTH(CW),
    .BYPASS_DONE(1'b1), .FWD_STORE_DATA(1'b0)
  ) dut (
    .clk(clk), .rstn(rstn), .hz(hif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: set of outstanding destinations plus sticky error.
  bit m_pend [32];
  bit m_err;

  function automatic int outstanding();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic int exp_fwd(input int rs);
    if (rs == 0) return 0;
    if (hif.done_valid && int'(hif.done_rd) == rs) return 3;
    if (hif.regwriteM && int'(hif.rdM) == rs) return 2;
    if (hif.regwriteW && int'(hif.rdW) == rs) return 1;
    return 0;
  endfunction

  // A source must wait if its producer is outstanding or being allocated,
  // unless its value is on the completion bus right now.
  function automatic bit exp_raw(input bit used, input int rs);
    bit busy, alloc_now, on_bus;
    alloc_now = hif.alloc_valid && int'(hif.alloc_rd) == rs;
    busy = m_pend[rs] || alloc_now;
    on_bus = hif.done_valid && int'(hif.done_rd) == rs && !alloc_now;
    return used && rs != 0 && busy && !on_bus;
  endfunction

  task automatic idle_inputs();
    hif.rs1D = '0; hif.rs2D = '0; hif.rdD = '0;
    hif.rs1_usedD = 0; hif.rs2_usedD = 0; hif.regwriteD = 0; hif.longopD = 0;
    hif.alloc_valid = 0; hif.alloc_rd = '0;
    hif.done_valid = 0; hif.done_rd = '0;
    hif.rs1E = '0; hif.rs2E = '0; hif.stypeE = 0;
    hif.regwriteM = 0; hif.rdM = '0; hif.regwriteW = 0; hif.rdW = '0;
    hif.branch_flush = 0;
  endtask

  task automatic check_comb();
    bit st;
    int occ;
    bit dhit;
    dhit = hif.done_valid && m_pend[int'(hif.done_rd)];
    occ = outstanding() + int'(hif.alloc_valid) - int'(dhit);
    st = exp_raw(hif.rs1_usedD, int'(hif.rs1D)) ||
         exp_raw(hif.rs2_usedD, int'(hif.rs2D)) ||
         (hif.regwriteD && hif.rdD != 0 &&
          (m_pend[int'(hif.rdD)] || (hif.alloc_valid && hif.alloc_rd == hif.rdD))) ||
         (hif.longopD && occ >= MAXO);
    chk("stallF", int'(hif.stallF), hif.branch_flush ? 0 : int'(st));
    chk("stallD", int'(hif.stallD), hif.branch_flush ? 0 : int'(st));
    chk("flushD", int'(hif.flushD), int'(hif.branch_flush));
    chk("flushE", int'(hif.flushE), hif.branch_flush ? 1 : int'(st));
    chk("forwardA", int'(hif.forwardA), exp_fwd(int'(hif.rs1E)));
    chk("forwardB", int'(hif.forwardB), hif.stypeE ? 0 : exp_fwd(int'(hif.rs2E)));
  endtask

  task automatic model_edge();
    bit dhit, aeff;
    int ar, dr;
    ar = int'(hif.alloc_rd);
    dr = int'(hif.done_rd);
    dhit = hif.done_valid && m_pend[dr];
    aeff = hif.alloc_valid && ar != 0;
    if (hif.done_valid && !dhit) m_err = 1;
    if (aeff && outstanding() == MAXO && !dhit) begin
      m_err = 1;
    end else begin
      if (dhit) m_pend[dr] = 0;
      if (aeff) m_pend[ar] = 1;
    end
  endtask

  // allow_err: permit completions for non-pending regs and full-table allocs.
  task automatic rand_cycle(input bit allow_err);
    int q[$];
    int r;
    for (int i = 1; i < 8; i++) if (m_pend[i]) q.push_back(i);
    hif.done_valid = ($urandom_range(0, 2) == 0);
    if (hif.done_valid) begin
      if (q.size() > 0 && !(allow_err && $urandom_range(0, 9) == 0))
        hif.done_rd = RW'(q[$urandom_range(0, q.size() - 1)]);
      else if (allow_err || q.size() == 0)
        hif.done_rd = RW'($urandom_range(0, 7));
      if (!allow_err && !m_pend[int'(hif.done_rd)]) hif.done_valid = 0;
    end
    hif.alloc_valid = ($urandom_range(0, 1) == 0);
    r = $urandom_range(0, 7);
    hif.alloc_rd = RW'(r);
    // Keep the table consistent: never re-allocate a register still pending
    // unless it completes in the same cycle.
    if (m_pend[r] && !(hif.done_valid && int'(hif.done_rd) == r && m_pend[r]))
      hif.alloc_rd = '0;
    if (hif.done_valid && !m_pend[int'(hif.done_rd)] && hif.done_rd == hif.alloc_rd)
      hif.alloc_valid = 0;
    if (!allow_err && hif.alloc_valid && hif.alloc_rd != 0 && outstanding() == MAXO &&
        !(hif.done_valid && m_pend[int'(hif.done_rd)]))
      hif.alloc_valid = 0;
    hif.rs1D = RW'($urandom_range(0, 7)); hif.rs2D = RW'($urandom_range(0, 7));
    hif.rdD = RW'($urandom_range(0, 7));
    hif.rs1_usedD = 1'($urandom); hif.rs2_usedD = 1'($urandom);
    hif.regwriteD = 1'($urandom); hif.longopD = 1'($urandom);
    hif.rs1E = RW'($urandom_range(0, 7)); hif.rs2E = RW'($urandom_range(0, 7));
    hif.stypeE = ($urandom_range(0, 3) == 0);
    hif.regwriteM = 1'($urandom); hif.rdM = RW'($urandom_range(0, 7));
    hif.regwriteW = 1'($urandom); hif.rdW = RW'($urandom_range(0, 7));
    hif.branch_flush = ($urandom_range(0, 7) == 0);
  endtask

  task automatic run_cycles(input int n, input bit allow_err);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rand_cycle(allow_err);
      #1 check_comb();
      @(posedge clk);
      model_edge();
      #1;
      chk("pending_cnt", int'(hif.pending_cnt), outstanding());
      chk("sb_err", int'(hif.sb_err), int'(m_err));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_err = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rstn = 0;
    #12;
    chk("rst_cnt", int'(hif.pending_cnt), 0);
    chk("rst_err", int'(hif.sb_err), 0);
    check_comb();
    @(negedge clk);
    rstn = 1;

    run_cycles(300, 1'b0);

    // Asynchronous reset away from any clock edge, with work outstanding.
    @(negedge clk);
    idle_inputs();
    hif.alloc_valid = 1; hif.alloc_rd = RW'(6);
    if (m_pend[6]) hif.alloc_rd = '0;
    @(posedge clk);
    model_edge();
    #2 rstn = 0;
    #1;
    model_reset();
    chk("async_rst_cnt", int'(hif.pending_cnt), 0);
    chk("async_rst_err", int'(hif.sb_err), 0);
    idle_inputs();
    @(negedge clk);
    rstn = 1;

    run_cycles(300, 1'b1);

    @(negedge clk);
    idle_inputs();
    rstn = 0;
    #1;
    model_reset();
    chk("final_rst_err", int'(hif.sb_err), 0);
    chk("final_rst_cnt", int'(hif.pending_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
